// File: rtl/simon_button_ctrl.sv
// simon_button_ctrl: push-button front end for the Simon game.
// Synchronises and debounces NBTN raw buttons, converts clean press edges into
// single press events and hands one button ID per physical press to the game
// FSM over a valid/ready handshake. New events are locked out until every
// button is released.
// Optional build macro SIMUL_REJECT_EN: when defined, a press that arrives
// while more than one clean button is held is rejected instead of arbitrated.
module simon_button_ctrl #(
  parameter int unsigned NBTN   = 4,
  parameter int unsigned DB_CYC = 4194304,
  parameter int unsigned CNT_W  = 23,
  parameter int unsigned IDW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] raw,
  input  logic            enable,
  output logic [NBTN-1:0] clean,
  output logic            press_valid,
  output logic [IDW-1:0]  press_id,
  input  logic            press_ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYC - 1);

  logic [NBTN-1:0]  sync1_q, sync1_d;
  logic [NBTN-1:0]  sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  logic [NBTN-1:0]  clean_q, clean_d;
  logic [NBTN-1:0]  clean_dly_q, clean_dly_d;
  state_t           state_q, state_d;
  logic             press_valid_q, press_valid_d;
  logic [IDW-1:0]   press_id_q, press_id_d;

  logic [NBTN-1:0]  rise;
  logic [IDW-1:0]   low_id;
  logic             low_found;

  // Two-flop synchroniser chain for the asynchronous button levels.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // Per-button debounce: clean flips only after DB_CYC consecutive differing samples.
  always_comb begin
    clean_d = clean_q;
    for (int unsigned i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    clean_dly_d = clean_q;
  end

  assign rise = clean_q & ~clean_dly_q;

  // Priority encoder: index of the lowest rising button.
  always_comb begin
    low_id    = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (rise[i] && !low_found) begin
        low_id    = IDW'(i);
        low_found = 1'b1;
      end
    end
  end

`ifdef SIMUL_REJECT_EN
  logic multi_held;
  assign multi_held = (clean_q & (clean_q - 1'b1)) != '0;
`endif

  // Press FSM next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    press_valid_d = press_valid_q;
    press_id_d    = press_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (rise != '0)) begin
`ifdef SIMUL_REJECT_EN
          if (multi_held) begin
            state_d = ST_RELEASE;
          end else begin
            press_valid_d = 1'b1;
            press_id_d    = low_id;
            state_d       = ST_PRESS;
          end
`else
          press_valid_d = 1'b1;
          press_id_d    = low_id;
          state_d       = ST_PRESS;
`endif
        end
      end
      ST_PRESS: begin
        if (press_ready) begin
          press_valid_d = 1'b0;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (clean_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        press_valid_d = 1'b0;
      end
    endcase
  end

  // State register for synchroniser, debounce, edge detect and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q       <= '0;
      clean_dly_q   <= '0;
      state_q       <= ST_IDLE;
      press_valid_q <= 1'b0;
      press_id_q    <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      for (int unsigned i = 0; i < NBTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q       <= clean_d;
      clean_dly_q   <= clean_dly_d;
      state_q       <= state_d;
      press_valid_q <= press_valid_d;
      press_id_q    <= press_id_d;
    end
  end

  assign clean       = clean_q;
  assign press_valid = press_valid_q;
  assign press_id    = press_id_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/simon_button_ctrl.md
Name: simon_button_ctrl

Overview:
- Front-end controller for the game's push-buttons.
- Synchronises and debounces NBTN raw button inputs, then turns clean press edges into single press events.
- Arbitrates simultaneous presses and locks out new events until every button is released.
- Delivers one button ID per physical press to the game FSM over a valid/ready handshake.

Parameters:
NBTN, 4, number of buttons (2..8)
DB_CYC, 4194304, consecutive cycles a synchronised input must differ from its clean value before the clean value flips
CNT_W, 23, debounce counter width; must hold DB_CYC-1
IDW, 2, press_id width; must be at least clog2(NBTN)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
raw  in  NBTN  raw button levels, asynchronous, 1 = pressed
enable  in  1  arms press detection; 0 blocks new events from IDLE only
clean  out  NBTN  debounced button levels
press_valid  out  1  press event pending
press_id  out  IDW  index of pressed button; stable while press_valid=1
press_ready  in  1  consumer accepts the event when valid and ready are both 1
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0, async) clears sync flops, counters, clean, clean_d, press_valid, press_id and busy; FSM goes to IDLE.
- Synchroniser: each raw bit passes through a 2-flop synchroniser giving sync[i].
- Debounce, per bit, independent counter cnt[i]:
  - sync[i]==clean[i] -> cnt[i] <= 0.
  - sync[i]!=clean[i] and cnt[i]<DB_CYC-1 -> cnt[i] <= cnt[i]+1.
  - sync[i]!=clean[i] and cnt[i]==DB_CYC-1 -> clean[i] <= sync[i], cnt[i] <= 0.
  - A glitch shorter than DB_CYC cycles never changes clean.
  - Latency from a raw change to clean is 2+DB_CYC cycles.
- Edge detect: clean_d is clean delayed by one cycle; rise = clean & ~clean_d.
- FSM states:
  - IDLE: if enable=1 and rise!=0, press_id <= index of the lowest set bit of rise, press_valid <= 1, go to PRESS. Otherwise stay in IDLE.
  - PRESS: press_valid=1 and press_id held. On press_ready=1, press_valid <= 0 and go to RELEASE. Enable and further rises are ignored in this state.
  - RELEASE: wait until clean==0, then go to IDLE on the next cycle.
- busy = (state != IDLE).
- Boundary conditions:
  - A button already held when enable rises produces no event; detection is edge-based.
  - Two bits rising in the same cycle: the lowest index wins and the other rise is discarded.
  - A rise that occurs while in PRESS or RELEASE is discarded, not queued.
  - press_ready=1 while press_valid=0 has no effect.
  - Valid-to-accept latency is 0 cycles: an event can be accepted in the first cycle press_valid is high.
  - rst_n asserted in PRESS drops press_valid immediately, with no handshake.

Optional Feature:
SIMUL_REJECT_EN
- Defined: in IDLE with enable=1 and rise!=0, if clean has more than one bit set, no event is issued and the FSM goes straight to RELEASE (a multi-button press is rejected).
- Not defined: the lowest-index-wins arbitration described above applies.

Test Plan:
- Bench parameters: NBTN=4, DB_CYC=4.
- Debounce: raw[2] high for 3 cycles then low -> clean stays 0000; raw[2] held high -> clean[2]=1 exactly 6 cycles after raw rises.
- Single press: enable=1, raw=0100 held, press_ready=1 -> one press_valid pulse with press_id=2; no second event while raw stays high; after raw=0000 and debounce, busy=0.
- Backpressure: press_ready=0 for 10 cycles after press_valid -> press_valid and press_id=1 stay stable; ready=1 -> valid drops the next cycle and the FSM enters RELEASE.
- Simultaneous press: raw 0000 -> 1010 in one cycle:
  - without SIMUL_REJECT_EN -> press_id=1;
  - with it -> no press_valid, busy=1 until clean=0000.
- Enable gating: raw[3] pressed with enable=0, then enable=1 while held -> no event; release and press again -> press_id=3.
- Reset mid-operation: rst_n pulsed low while press_valid=1 -> press_valid, clean and busy are 0 asynchronously; after release of rst_n with raw held, the debounce restarts (clean[i] rises 6 cycles after reset release).
